// File: rtl/fetch_unit.sv
// Instruction fetch front end for ROM port A.
// Keeps the PC, issues one fetch per cycle under a credit limit, tracks the
// fixed ROM read latency with a tag pipe, replays fetches the ROM did not
// validate, and buffers returned words with their PC for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned FQ_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               rom_addr,
    input  logic [31:0]               rom_data,
    input  logic                      rom_valid,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      inst_valid,
    output logic [31:0]               inst_data,
    output logic [31:0]               inst_pc,
    input  logic                      inst_ready,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);

    logic [31:0]      pc;
    logic             tagValid [ROM_LATENCY];
    logic [31:0]      tagPc    [ROM_LATENCY];
    logic [31:0]      qData    [FQ_DEPTH];
    logic [31:0]      qPc      [FQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic [31:0]      inflight;
    logic             retValid;
    logic [31:0]      retPc;
    logic             doIssue;
    logic             doPush;
    logic             doPop;
    logic             doReplay;

    // Count fetches still travelling through the ROM; they hold queue credit.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + {31'b0, tagValid[i]};
        end
    end

    // Decode this cycle's return, issue and handshake events; redirect wins over all.
    always_comb begin
        retValid = tagValid[ROM_LATENCY-1];
        retPc    = tagPc[ROM_LATENCY-1];
        doPush   = retValid & rom_valid & ~redirect_valid;
        doReplay = retValid & ~rom_valid & ~redirect_valid;
        doPop    = inst_valid & inst_ready & ~redirect_valid;
        doIssue  = ((32'(count) + inflight) < FQ_DEPTH) & ~redirect_valid & ~doReplay;
    end

    // Program counter: redirect, replay of an unvalidated fetch, or sequential advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (doReplay) begin
            pc <= retPc;
        end else if (doIssue) begin
            pc <= pc + 32'd4;
        end
    end

    // Tag pipe mirrors the ROM latency; a replay or redirect kills every younger fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                tagValid[i] <= 1'b0;
                tagPc[i]    <= '0;
            end
        end else if (redirect_valid || doReplay) begin
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                tagValid[i] <= 1'b0;
            end
        end else begin
            tagValid[0] <= doIssue;
            tagPc[0]    <= pc;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagPc[i]    <= tagPc[i-1];
            end
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                tail <= tail + 1'b1;
            end
            if (doPop) begin
                head <= head + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (!doPush && doPop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Queue storage needs no reset: empty entries are never shown to decode.
    always_ff @(posedge clk) begin
        if (doPush) begin
            qData[tail] <= rom_data;
            qPc[tail]   <= retPc;
        end
    end

    // Head of queue presented to decode, forced to zero when empty.
    always_comb begin
        rom_addr   = pc;
        fq_count   = count;
        inst_valid = (count != '0);
        inst_data  = inst_valid ? qData[head] : '0;
        inst_pc    = inst_valid ? qPc[head] : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a latency-2 ROM whose
// word at byte address 4*k holds k. Accepted instructions are checked against
// a program-order model: since the last reset/redirect, PCs run upward by 4.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  fq_count;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ROM_LATENCY(2),
        .FQ_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rom_valid     (rom_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .fq_count      (fq_count)
    );

    always #5 clk = ~clk;

    // ROM model: two-cycle read latency, data = address / 4
    logic [31:0] romA1;
    logic [31:0] romA2;
    always @(posedge clk) begin
        romA1 <= rom_addr;
        romA2 <= romA1;
    end
    assign rom_data = romA2 >> 2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expPc;
    int          accepted = 0;
    logic [31:0] lastPc;
    bit          dropArm  = 1'b0;
    bit          dropDone = 1'b0;
    bit          randDrop = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set; observes, updates model, advances one cycle.
    task automatic runCycle();
        rom_valid = 1'b1;
        if (dropArm && romA2 == 32'd8) begin
            rom_valid = 1'b0;
            dropArm   = 1'b0;
            dropDone  = 1'b1;
        end else if (randDrop && $urandom_range(0, 9) == 0) begin
            rom_valid = 1'b0;
        end
        #1;
        if (redirect_valid) begin
            expPc = redirect_pc & 32'hFFFF_FFFC;
        end else if (inst_valid && inst_ready) begin
            checkEq("order_pc", inst_pc, expPc);
            checkEq("order_data", inst_data, expPc >> 2);
            lastPc = inst_pc;
            accepted++;
            expPc = expPc + 32'd4;
        end
        if (!inst_valid) begin
            checkEq("empty_data", inst_data, 32'd0);
            checkEq("empty_pc", inst_pc, 32'd0);
        end
        checkEq("fq_bound", {31'b0, (fq_count <= 3'd4)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkEq({tag, "_addr"}, rom_addr, 32'd0);
        checkEq({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        checkEq({tag, "_data"}, inst_data, 32'd0);
        checkEq({tag, "_pc"}, inst_pc, 32'd0);
        checkEq({tag, "_cnt"}, {29'b0, fq_count}, 32'd0);
    endtask

    // Asserts reset asynchronously for one cycle, checking outputs during it.
    task automatic doReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        #1;
        checkResetOutputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst_hold");
        reset = 1'b0;
        expPc = 32'h0000_0000;
    endtask

    task automatic consume(input int n, input int maxCycles);
        int target;
        int c;
        target = accepted + n;
        c = 0;
        while (accepted < target && c < maxCycles) begin
            runCycle();
            c++;
        end
        checkEq("consume_done", {31'b0, (accepted >= target)}, 32'd1);
    endtask

    task automatic waitValid(input int maxCycles);
        int c;
        c = 0;
        while (!inst_valid && c < maxCycles) begin
            runCycle();
            c++;
        end
        checkEq("wait_valid", {31'b0, inst_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rom_valid      = 1'b1;
        expPc          = '0;
        lastPc         = '0;
        doReset();

        // 1: latency and streaming throughput
        inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checkEq("t1_latency", {31'b0, inst_valid}, 32'd0);
            runCycle();
        end
        checkEq("t1_first", {31'b0, inst_valid}, 32'd1);
        checkEq("t1_pc0", inst_pc, 32'd0);
        for (int c = 0; c < 8; c++) begin
            checkEq("t1_stream", {31'b0, inst_valid}, 32'd1);
            runCycle();
        end

        // 2: back-pressure saturates the queue without over-issuing
        doReset();
        inst_ready = 1'b0;
        repeat (20) runCycle();
        checkEq("t2_full", {29'b0, fq_count}, 32'd4);
        checkEq("t2_pc_hold", rom_addr, 32'd16);
        inst_ready = 1'b1;
        consume(5, 40);
        checkEq("t2_last", lastPc, 32'd16);

        // 3: redirect flushes queue and in-flight fetches
        doReset();
        inst_ready = 1'b0;
        for (int c = 0; c < 20 && fq_count != 3'd3; c++) runCycle();
        checkEq("t3_pre", {29'b0, fq_count}, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0033;
        runCycle();
        checkEq("t3_flush", {29'b0, fq_count}, 32'd0);
        checkEq("t3_novalid", {31'b0, inst_valid}, 32'd0);
        inst_ready = 1'b1;
        waitValid(10);
        checkEq("t3_newpc", inst_pc, 32'h30);
        consume(4, 30);

        // 4: unvalidated return for PC 8 is replayed
        doReset();
        inst_ready = 1'b1;
        dropArm    = 1'b1;
        dropDone   = 1'b0;
        consume(6, 60);
        checkEq("t4_dropped", {31'b0, dropDone}, 32'd1);
        checkEq("t4_last", lastPc, 32'd20);

        // 5: PC wraps past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        runCycle();
        consume(3, 20);
        checkEq("t5_wrap", lastPc, 32'h0000_0000);

        // 6: reset mid-stream with a full queue
        inst_ready = 1'b0;
        repeat (20) runCycle();
        checkEq("t6_full", {29'b0, fq_count}, 32'd4);
        doReset();
        inst_ready = 1'b1;
        waitValid(10);
        checkEq("t6_restart", inst_pc, 32'd0);
        consume(4, 20);

        // Random: back-pressure, ROM invalid returns and occasional redirects
        doReset();
        randDrop = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            runCycle();
        end
        randDrop = 1'b0;
        checkEq("rand_progress", {31'b0, (accepted > 1000)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
